// File: rtl/core_pkg.sv
// Shared RV32I opcode encodings and immediate-format classification for the
// front end (fetch, decode and the IF/ID register).
package core_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } immode_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic immode_e decode_immode(input logic [31:0] ins);
        immode_e mode;
        case (ins[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: mode = IMM_I;
            OPC_STORE:                                  mode = IMM_S;
            OPC_BRANCH:                                 mode = IMM_B;
            OPC_LUI, OPC_AUIPC:                         mode = IMM_U;
            OPC_JAL:                                    mode = IMM_J;
            default:                                    mode = IMM_NONE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with flush; holds fetched {ins, pc} entries and
// the PCs of requests still in flight to instruction memory.
module fetch_queue #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full queue is allowed when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues in-order imem requests
// under a 2-credit limit and presents buffered responses to IF/ID.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int unsigned          WordSize    = 32,
    parameter logic [WordSize-1:0]  ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WordSize-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_pc,
    input  logic                stall,
    output logic                ifid_valid,
    output logic [31:0]         ifid_ins,
    output logic [WordSize-1:0] ifid_pc,
    output logic [2:0]          ifid_immode
);

    localparam int unsigned EntryW = 32 + WordSize;

    logic [WordSize-1:0] pc_q, pc_d;
    logic [1:0]          outstanding_q, outstanding_d;
    logic [1:0]          drop_q, drop_d;

    logic                accept;
    logic                rsp_push;
    logic                data_pop;
    logic [EntryW-1:0]   data_head;
    logic                data_full, data_empty;
    logic [1:0]          data_count;
    logic [WordSize-1:0] infl_head;
    logic                infl_full, infl_empty;
    logic [1:0]          infl_count;
    immode_e             head_mode;

    // Credits come from registered counts only, so a same-cycle pop never frees one.
    assign imem_req_valid = rstn && !redirect
                         && (({1'b0, outstanding_q} + {1'b0, data_count}) < 3'd2);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_push = imem_rsp_valid && !redirect && (drop_q == 2'd0);
    assign data_pop = ifid_valid && !stall && !redirect;

    fetch_queue #(.Width(WordSize)) u_infl_q (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (infl_head),
        .full      (infl_full),
        .empty     (infl_empty),
        .count     (infl_count)
    );

    fetch_queue #(.Width(EntryW)) u_data_q (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rsp_push),
        .push_data ({imem_rsp_data, infl_head}),
        .pop       (data_pop),
        .flush     (redirect),
        .head      (data_head),
        .full      (data_full),
        .empty     (data_empty),
        .count     (data_count)
    );

    // Redirect turns everything still in flight (minus a same-cycle response,
    // itself discarded) into drop credit on top of any drop already pending.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + 2'(accept) - 2'(imem_rsp_valid);
        drop_d        = drop_q;
        if (redirect) begin
            pc_d   = redirect_pc;
            drop_d = outstanding_q - 2'(imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + WordSize'(4);
            end
            if (imem_rsp_valid && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q          <= ResetVector;
            outstanding_q <= 2'd0;
            drop_q        <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (outstanding_q <= 2'd2);
            assert (data_count <= 2'd2);
            assert (drop_q <= outstanding_q);
            assert (!(imem_rsp_valid && (outstanding_q == 2'd0)));
            assert (infl_count == outstanding_q);
            assert (!(imem_rsp_valid && infl_empty));
            assert (!(accept && infl_full));
            assert (!(rsp_push && data_full && !data_pop));
        end
    end

    assign ifid_valid  = !data_empty;
    assign ifid_ins    = ifid_valid ? data_head[EntryW-1 -: 32] : '0;
    assign ifid_pc     = ifid_valid ? data_head[WordSize-1:0] : '0;
    assign head_mode   = decode_immode(ifid_ins);
    assign ifid_immode = head_mode;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural imem model and an
// {ins, pc} scoreboard filled on request accept and drained on IF/ID pop.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_ins;
    logic [31:0] ifid_pc;
    logic [2:0]  ifid_immode;

    always #5 clk = ~clk;

    fetch_ctrl #(.WordSize(32), .ResetVector(RESET_VEC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ifid_valid     (ifid_valid),
        .ifid_ins       (ifid_ins),
        .ifid_pc        (ifid_pc),
        .ifid_immode    (ifid_immode)
    );

    typedef struct { logic [31:0] ins; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        sb[$];
    mreq_t       mp[$];
    logic [31:0] pop_pc_log[$];
    logic [2:0]  pop_imm_log[$];

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          lat = 1;
    int          first_acc_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] exp_pc = RESET_VEC;
    logic [31:0] prev_acc_addr = '0;
    bit          wrap_seen = 1'b0;

    logic        s_req_valid, s_ifid_valid;
    logic [31:0] s_req_addr, s_ifid_ins, s_ifid_pc;
    logic [2:0]  s_ifid_imm;

    function automatic logic [31:0] ins_at(input logic [31:0] addr);
        logic [6:0] opc;
        if (addr == 32'h0) return 32'h0050_0093;
        if (addr == 32'h4) return 32'h0011_2023;
        case (addr[4:2])
            3'd0: opc = 7'b0010011;
            3'd1: opc = 7'b0100011;
            3'd2: opc = 7'b1100011;
            3'd3: opc = 7'b0110111;
            3'd4: opc = 7'b1101111;
            3'd5: opc = 7'b0000011;
            3'd6: opc = 7'b0110011;
            default: opc = 7'b1110011;
        endcase
        return {addr[26:2], opc};
    endfunction

    function automatic logic [2:0] exp_mode(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
            7'h23:                      return 3'd2;
            7'h63:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h6f:                      return 3'd5;
            default:                    return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < pop_pc_log.size()) return pop_pc_log[i];
        return 'x;
    endfunction

    function automatic logic [2:0] imm_at(input int i);
        if (i < pop_imm_log.size()) return pop_imm_log[i];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-low-phase, update models, step the edge,
    // then drive the memory response for the next cycle on the falling edge.
    task automatic tick();
        exp_t  e;
        mreq_t m;
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_ifid_valid = ifid_valid;
        s_ifid_ins   = ifid_ins;
        s_ifid_pc    = ifid_pc;
        s_ifid_imm   = ifid_immode;
        if (!rstn) begin
            sb.delete();
            mp.delete();
            exp_pc = RESET_VEC;
        end else begin
            if (s_ifid_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (s_ifid_valid && !stall && !redirect) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pop_ins", s_ifid_ins, e.ins);
                    chk("pop_pc", s_ifid_pc, e.pc);
                    chk("pop_immode", s_ifid_imm, exp_mode(e.ins));
                    pop_pc_log.push_back(s_ifid_pc);
                    pop_imm_log.push_back(s_ifid_imm);
                end
            end
            if (s_req_valid && imem_req_ready) begin
                chk("req_addr", s_req_addr, exp_pc);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (s_req_addr == 32'h0 && prev_acc_addr == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                prev_acc_addr = s_req_addr;
                m.addr = s_req_addr;
                m.due  = cyc + lat;
                mp.push_back(m);
                e.ins = ins_at(exp_pc);
                e.pc  = exp_pc;
                sb.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) begin
                sb.delete();
                exp_pc = redirect_pc;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (mp.size() > 0 && mp[0].due <= cyc) begin
            m = mp.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins_at(m.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic quiesce(input string tag);
        imem_req_ready = 1'b0;
        for (int i = 0; i < 40 && (mp.size() != 0 || imem_rsp_valid || sb.size() != 0); i++) tick();
        chk(tag, 64'(mp.size() == 0 && !imem_rsp_valid && sb.size() == 0), 64'd1);
    endtask

    task automatic wait_two_out(input string tag);
        for (int i = 0; i < 20 && !(mp.size() == 2 && !imem_rsp_valid); i++) tick();
        chk(tag, 64'(mp.size() == 2 && !imem_rsp_valid), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_valid"}, s_req_valid, 0);
        chk({tag, "_req_addr"}, s_req_addr, RESET_VEC);
        chk({tag, "_ifid_valid"}, s_ifid_valid, 0);
        chk({tag, "_ifid_ins"}, s_ifid_ins, 0);
        chk({tag, "_ifid_pc"}, s_ifid_pc, 0);
        chk({tag, "_ifid_immode"}, s_ifid_imm, 0);
    endtask

    initial begin
        logic [31:0] held_pc, held_ins;

        // Reset, then stream with a 1-cycle memory
        rstn = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rstn = 1'b1;
        imem_req_ready = 1'b1;
        lat = 1;
        repeat (8) tick();
        chk("first_valid_latency", 64'(first_valid_cyc - first_acc_cyc), 64'd2);
        chk("stream_pc0", log_at(0), RESET_VEC);
        chk("stream_imm0", imm_at(0), 3'd1);
        chk("stream_pc1", log_at(1), RESET_VEC + 32'd4);
        chk("stream_imm1", imm_at(1), 3'd2);

        // Stall for 6 cycles: queue fills, head holds, requests stop
        stall = 1'b1;
        tick();
        tick();
        held_pc  = s_ifid_pc;
        held_ins = s_ifid_ins;
        chk("stall_valid", s_ifid_valid, 1);
        repeat (4) begin
            tick();
            chk("stall_head_pc", s_ifid_pc, held_pc);
            chk("stall_head_ins", s_ifid_ins, held_ins);
        end
        chk("stall_no_req", s_req_valid, 0);
        chk("stall_full_valid", s_ifid_valid, 1);
        stall = 1'b0;
        repeat (10) tick();

        // Redirect with two requests in flight
        quiesce("quiesce_t4");
        lat = 3;
        imem_req_ready = 1'b1;
        wait_two_out("t4_two_outstanding");
        pop_pc_log.delete();
        pop_imm_log.delete();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        chk("t4_no_req_on_redirect", s_req_valid, 0);
        redirect = 1'b0;
        tick();
        chk("t4_ifid_flushed", s_ifid_valid, 0);
        repeat (15) tick();
        chk("t4_first_pc", log_at(0), 32'h0000_0100);
        chk("t4_second_pc", log_at(1), 32'h0000_0104);

        // Redirect together with stall while the queue is full
        quiesce("quiesce_t5");
        lat = 1;
        imem_req_ready = 1'b1;
        stall = 1'b1;
        repeat (6) tick();
        chk("t5_full_valid", s_ifid_valid, 1);
        chk("t5_full_no_req", s_req_valid, 0);
        pop_pc_log.delete();
        pop_imm_log.delete();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        tick();
        chk("t5_ifid_flushed", s_ifid_valid, 0);
        chk("t5_resume_addr", s_req_addr, 32'h0000_0200);
        repeat (10) tick();
        chk("t5_first_pc", log_at(0), 32'h0000_0200);

        // Reset mid-stream with two outstanding, then PC wrap
        quiesce("quiesce_t6");
        lat = 3;
        imem_req_ready = 1'b1;
        wait_two_out("t6_two_outstanding");
        rstn = 1'b0;
        tick();
        tick();
        check_zero("t6_reset");
        rstn = 1'b1;
        tick();
        chk("t6_restart_valid", s_req_valid, 1);
        chk("t6_restart_addr", s_req_addr, RESET_VEC);
        quiesce("quiesce_wrap");
        lat = 1;
        imem_req_ready = 1'b1;
        pop_pc_log.delete();
        pop_imm_log.delete();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (12) tick();
        chk("wrap_seen", 64'(wrap_seen), 64'd1);
        chk("wrap_pc0", log_at(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", log_at(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", log_at(2), 32'h0000_0000);
        chk("wrap_imm2", imm_at(2), 3'd1);

        quiesce("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
